imm_gen_pipe: RTL and testbench
===============================

// Module: imm_gen_pipe
// PURPOSE
//  Pipelined, parametrised immediate generator for the decode stage of the RISC-V core.
//  Accepts one instruction plus PC per cycle over a valid/ready handshake and extracts the immediate.
//  Sign-extends it to XLEN and computes the PC-relative target (pc + imm) in a second stage.
//  Sits between fetch/decode and the execute/branch unit; absorbs downstream stalls without losing data.
// PARAMETERS
//  XLEN    32  datapath width of imm/pc/target; legal values 32 or 64
//  ERR_W   16  width of the saturating illegal-format counter
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      instr/imm_src/pc valid this cycle
//  in_ready    out  1      stage 1 can accept; transfer when in_valid&&in_ready
//  instr       in   32     raw instruction word
//  imm_src     in   3      format select (see BEHAVIOUR)
//  pc          in   XLEN   PC of instr
//  out_valid   out  1      stage 2 holds a result
//  out_ready   in   1      consumer accepts; transfer when out_valid&&out_ready
//  out_imm     out  XLEN   extended immediate
//  out_target  out  XLEN   pc + out_imm, modulo 2^XLEN
//  out_err     out  1      result came from an illegal imm_src
//  err_cnt     out  ERR_W  count of illegal-format transfers, saturates at all-ones
// BEHAVIOUR
//  - Reset (rst_n=0, async): s1/s2 valid=0, out_valid=0, out_imm=out_target=0, out_err=0, err_cnt=0.
//  - imm_src: 000 I {sx,i[31:20]}; 001 S {sx,i[31:25],i[11:7]};
//    010 B {sx,i[31],i[7],i[30:25],i[11:8],0}; 011 J {sx,i[31],i[19:12],i[20],i[30:21],0};
//    100 U {i[31:12],12'b0}, then sign-extended from bit 31 when XLEN=64.
//  - 101: see CONFIGURATION. 110/111 illegal: imm=0, err=1.
//  - sx means replicate i[31] up to XLEN.
//  - Stage 1 registers imm, pc, err. Stage 2 registers imm, pc+imm, err.
//  - Latency: 2 cycles from input transfer to out_valid when there is no stall.
//  - Throughput: 1 per cycle.
//  - adv2 = !s2_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1.
//  - in_ready is combinational from out_ready; no combinational path from in_valid to out_valid.
//  - Stall (out_ready=0 with both stages full): in_ready=0.
//  - While stalled, out_* and stage-1 contents are held stable and bit-exact until accepted.
//  - Simultaneous input and output transfer with both stages full: every stage shifts.
//  - No bubble is inserted and no data is lost.
//  - out_valid and out_* change only when adv2=1.
//  - Data registers are not cleared when a stage empties; consumers must qualify on out_valid.
//  - err_cnt increments by 1 when an entry with err=1 transfers on the output handshake.
//  - err_cnt holds at 2^ERR_W-1.
//  - Reset mid-operation: all in-flight entries are discarded immediately; no partial output.
//  - Target arithmetic is unsigned XLEN-bit add; wrap-around is not flagged.
// CONFIGURATION
//  Macro IMMGEN_ZIMM_EN:
//  - Defined: imm_src=101 selects CSR zimm = zero-extended instr[19:15], err=0.
//    out_target is still pc+imm.
//  - Undefined: 101 is illegal, the same as 110/111 (imm=0, err=1, counted).
// TESTING
//  1 I: instr=FFF00093, src=000, pc=0 -> out_imm=FFFFFFFF, target=FFFFFFFF, 2 cycles after accept.
//  2 B/S/J/U back-to-back, out_ready=1, XLEN=32:
//    FE000EE3/010/pc=100 -> imm=FFFFFFFC, target=FC;
//    FE000C23/001 -> imm=FFFFFFF8;
//    0080006F/011/pc=200 -> imm=8, target=208;
//    123450B7/100 -> imm=12345000.
//    One result per cycle.
//  3 Backpressure: stream 4 items, drop out_ready for 3 cycles at item 2.
//    -> in_ready=0 once both stages are full; out_* stable; all 4 emerge in order, none lost or duplicated.
//  4 Illegal: src=110 x3 accepted -> out_err=1 and imm=0 each; err_cnt=3.
//    With ERR_W=2, 5 errors -> err_cnt=3.
//  5 Reset mid-flight: assert rst_n=0 with 2 entries in flight -> out_valid=0 and err_cnt=0 immediately.
//    After release the next input appears after exactly 2 cycles.
//  6 XLEN=64, U instr 800000B7 -> imm=FFFFFFFF80000000.
//    With IMMGEN_ZIMM_EN, instr=000F9073/101 -> imm=1F, err=0; without it -> err=1.

Source files
------------

// File: rtl/imm_gen_if.sv
// Valid/ready bus between the decode-side producer, the immediate generator
// and the execute/branch consumer. `master` is the side that feeds
// instructions and consumes results. `slave` is the imm_gen_pipe side.
interface imm_gen_if #(
  parameter int XLEN  = 32,
  parameter int ERR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       instr;
  logic [2:0]        imm_src;
  logic [XLEN-1:0]   pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_imm;
  logic [XLEN-1:0]   out_target;
  logic              out_err;
  logic [ERR_W-1:0]  err_cnt;

  modport master (
    output in_valid, instr, imm_src, pc, out_ready,
    input  in_ready, out_valid, out_imm, out_target, out_err, err_cnt
  );

  modport slave (
    input  in_valid, instr, imm_src, pc, out_ready,
    output in_ready, out_valid, out_imm, out_target, out_err, err_cnt
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Two-stage RISC-V immediate generator with valid/ready flow control.
// Stage 1 holds the extracted and sign-extended immediate, the pc and an
// illegal-format flag. Stage 2 holds the immediate, pc+imm and the flag.
// Optional feature macro IMMGEN_ZIMM_EN makes imm_src=101 select the CSR zimm
// field. Without the macro, imm_src=101 is illegal.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int ERR_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  imm_gen_if.slave   bus
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [31:0]        instr;
  logic signed [31:0] dec_imm32;
  logic [XLEN-1:0]    dec_imm;
  logic               dec_err;
  logic               adv1, adv2;

  logic               s1_valid_q, s1_valid_d;
  logic [XLEN-1:0]    s1_imm_q,   s1_imm_d;
  logic [XLEN-1:0]    s1_pc_q,    s1_pc_d;
  logic               s1_err_q,   s1_err_d;
  logic               s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]    s2_imm_q,   s2_imm_d;
  logic [XLEN-1:0]    s2_tgt_q,   s2_tgt_d;
  logic               s2_err_q,   s2_err_d;
  logic [ERR_W-1:0]   err_cnt_q,  err_cnt_d;

  assign instr = bus.instr;

  // Decode the immediate as a signed 32-bit value. Widening to XLEN then sign-extends from bit 31.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    dec_imm32 = '0;
    dec_err   = 1'b0;
    case (bus.imm_src)
      3'b000: dec_imm32 = {{20{instr[31]}}, instr[31:20]};
      3'b001: dec_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      3'b010: dec_imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                           instr[11:8], 1'b0};
      3'b011: dec_imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                           instr[30:21], 1'b0};
      3'b100: dec_imm32 = {instr[31:12], 12'b0};
`ifdef IMMGEN_ZIMM_EN
      3'b101: dec_imm32 = {27'b0, instr[19:15]};
`endif
      default: dec_err  = 1'b1;
    endcase
  end

  assign dec_imm = XLEN'(dec_imm32);

  // A stage may move when the stage after it is empty or is moving this cycle.
  assign adv2 = !s2_valid_q || bus.out_ready;
  assign adv1 = !s1_valid_q || adv2;

  // Next-state for both stages and the error counter. Data registers only load on a real transfer.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_imm_d   = s1_imm_q;
    s1_pc_d    = s1_pc_q;
    s1_err_d   = s1_err_q;
    s2_valid_d = s2_valid_q;
    s2_imm_d   = s2_imm_q;
    s2_tgt_d   = s2_tgt_q;
    s2_err_d   = s2_err_q;
    err_cnt_d  = err_cnt_q;

    if (adv1) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        s1_imm_d = dec_imm;
        s1_pc_d  = bus.pc;
        s1_err_d = dec_err;
      end
    end

    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_imm_d = s1_imm_q;
        s2_tgt_d = s1_pc_q + s1_imm_q;
        s2_err_d = s1_err_q;
      end
    end

    if (s2_valid_q && bus.out_ready && s2_err_q && (err_cnt_q != ERR_MAX))
      err_cnt_d = err_cnt_q + ERR_W'(1);
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the data registers are reset as well as the valid bits, so that out_imm/out_target read 0 after reset.
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_imm_q   <= '0;
      s1_pc_q    <= '0;
      s1_err_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_imm_q   <= '0;
      s2_tgt_q   <= '0;
      s2_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments, so every flop samples values from before the edge.
      s1_valid_q <= s1_valid_d;
      s1_imm_q   <= s1_imm_d;
      s1_pc_q    <= s1_pc_d;
      s1_err_q   <= s1_err_d;
      s2_valid_q <= s2_valid_d;
      s2_imm_q   <= s2_imm_d;
      s2_tgt_q   <= s2_tgt_d;
      s2_err_q   <= s2_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign bus.in_ready   = adv1;
  assign bus.out_valid  = s2_valid_q;
  assign bus.out_imm    = s2_imm_q;
  assign bus.out_target = s2_tgt_q;
  assign bus.out_err    = s2_err_q;
  assign bus.err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe. dut_a is XLEN=32 with a 16-bit error counter.
// dut_b is XLEN=64 with a 2-bit error counter.
module tb_imm_gen_pipe;

  localparam int XA = 32, EA = 16, XB = 64, EB = 2, NV = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imm_gen_if #(.XLEN(XA), .ERR_W(EA)) bus_a ();
  imm_gen_if #(.XLEN(XB), .ERR_W(EB)) bus_b ();

  imm_gen_pipe #(.XLEN(XA), .ERR_W(EA)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  imm_gen_pipe #(.XLEN(XB), .ERR_W(EB)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  src;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] imm;
    logic [31:0] tgt;
    logic        err;
  } res_t;

  vec_t vecs[NV];
  res_t got_q[$];
  int   got_cyc[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output transfer of dut_a; values are stable at the falling edge.
  always @(negedge clk) begin
    if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
      got_q.push_back('{bus_a.out_imm, bus_a.out_target, bus_a.out_err});
      got_cyc.push_back(cyc);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_a(input vec_t v);
    bus_a.instr   = v.instr;
    bus_a.imm_src = v.src;
    bus_a.pc      = v.pc;
  endtask

  // Send one item to dut_b and check the result when it shows up.
  task automatic run_b(input string name, input logic [31:0] instr, input logic [2:0] src,
                       input logic [63:0] pc, input logic [63:0] e_imm,
                       input logic [63:0] e_tgt, input logic e_err);
    @(posedge clk); #1;
    bus_b.instr = instr; bus_b.imm_src = src; bus_b.pc = pc; bus_b.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    for (int k = 0; k < 5 && !bus_b.out_valid; k++) begin
      @(posedge clk); #1;
    end
    check({name, " valid"}, 64'(bus_b.out_valid), 64'd1);
    check({name, " imm"},   bus_b.out_imm,    e_imm);
    check({name, " tgt"},   bus_b.out_target, e_tgt);
    check({name, " err"},   64'(bus_b.out_err), 64'(e_err));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int   exp_errs;
    int   idx, occ;
    logic acc, emit, stalled_prev;
    res_t held;

    vecs[0] = '{32'hFFF00093, 3'b000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[1] = '{32'hFE000EE3, 3'b010, 32'h0000_0100, 32'hFFFF_FFFC, 32'h0000_00FC, 1'b0};
    vecs[2] = '{32'hFE000C23, 3'b001, 32'h0000_0300, 32'hFFFF_FFF8, 32'h0000_02F8, 1'b0};
    vecs[3] = '{32'h0080006F, 3'b011, 32'h0000_0200, 32'h0000_0008, 32'h0000_0208, 1'b0};
    vecs[4] = '{32'h123450B7, 3'b100, 32'h0000_1000, 32'h1234_5000, 32'h1234_6000, 1'b0};
    vecs[5] = '{32'h7FF00013, 3'b000, 32'h0000_0010, 32'h0000_07FF, 32'h0000_080F, 1'b0};
    vecs[6] = '{32'h123450B7, 3'b100, 32'hFFFF_FFF0, 32'h1234_5000, 32'h1234_4FF0, 1'b0};
    vecs[7] = '{32'hFFF00093, 3'b110, 32'h0000_0040, 32'h0000_0000, 32'h0000_0040, 1'b1};
    vecs[8] = '{32'hFFF00093, 3'b111, 32'h0000_0044, 32'h0000_0000, 32'h0000_0044, 1'b1};
`ifdef IMMGEN_ZIMM_EN
    vecs[9] = '{32'h000F9073, 3'b101, 32'h0000_0080, 32'h0000_001F, 32'h0000_009F, 1'b0};
`else
    vecs[9] = '{32'h000F9073, 3'b101, 32'h0000_0080, 32'h0000_0000, 32'h0000_0080, 1'b1};
`endif

    rst_n = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1; drive_a(vecs[0]);
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
    bus_b.instr = '0; bus_b.imm_src = '0; bus_b.pc = '0;
    #12;
    check("reset out_valid",  64'(bus_a.out_valid), 64'd0);
    check("reset out_imm",    64'(bus_a.out_imm), 64'd0);
    check("reset out_target", 64'(bus_a.out_target), 64'd0);
    check("reset out_err",    64'(bus_a.out_err), 64'd0);
    check("reset err_cnt",    64'(bus_a.err_cnt), 64'd0);
    check("reset in_ready",   64'(bus_a.in_ready), 64'd1);
    check("reset b out_imm",  bus_b.out_imm, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Two-cycle latency for a single I-type item.
    @(posedge clk); #1;
    drive_a(vecs[0]); bus_a.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    check("lat one edge valid", 64'(bus_a.out_valid), 64'd0);
    @(posedge clk); #1;
    check("lat two edge valid", 64'(bus_a.out_valid), 64'd1);
    check("lat imm",            64'(bus_a.out_imm), 64'hFFFF_FFFF);
    check("lat tgt",            64'(bus_a.out_target), 64'hFFFF_FFFF);
    @(posedge clk); #1;
    got_q.delete(); got_cyc.delete();

    // Back-to-back table stream with out_ready held high.
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive_a(vecs[i]); bus_a.in_valid = 1'b1;
      #1;
      check($sformatf("stream in_ready %0d", i), 64'(bus_a.in_ready), 64'd1);
    end
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    for (int k = 0; k < 20 && got_q.size() < NV; k++) @(posedge clk);
    #1;
    check("stream count", 64'(got_q.size()), 64'(NV));
    exp_errs = 0;
    for (int i = 0; i < NV && i < got_q.size(); i++) begin
      check($sformatf("vec%0d imm", i), 64'(got_q[i].imm), 64'(vecs[i].imm));
      check($sformatf("vec%0d tgt", i), 64'(got_q[i].tgt), 64'(vecs[i].tgt));
      check($sformatf("vec%0d err", i), 64'(got_q[i].err), 64'(vecs[i].err));
      if (i > 0) check($sformatf("vec%0d spacing", i), 64'(got_cyc[i] - got_cyc[i-1]), 64'd1);
      if (vecs[i].err) exp_errs++;
    end
    check("stream err_cnt", 64'(bus_a.err_cnt), 64'(exp_errs));

    // Backpressure: 4 items, out_ready low for cycles 3..5.
    got_q.delete(); got_cyc.delete();
    idx = 0; occ = 0; stalled_prev = 1'b0; held = '{'0, '0, 1'b0};
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      bus_a.out_ready = !(c >= 3 && c < 6);
      bus_a.in_valid  = (idx < 4);
      if (idx < 4) drive_a(vecs[idx + 1]);
      #1;
      check($sformatf("bp in_ready c%0d", c), 64'(bus_a.in_ready),
            64'(!(occ == 2 && !bus_a.out_ready)));
      if (stalled_prev) begin
        check($sformatf("bp hold imm c%0d", c), 64'(bus_a.out_imm), 64'(held.imm));
        check($sformatf("bp hold tgt c%0d", c), 64'(bus_a.out_target), 64'(held.tgt));
        check($sformatf("bp hold valid c%0d", c), 64'(bus_a.out_valid), 64'd1);
      end
      stalled_prev = bus_a.out_valid && !bus_a.out_ready;
      held = '{bus_a.out_imm, bus_a.out_target, bus_a.out_err};
      acc  = bus_a.in_valid && bus_a.in_ready;
      emit = bus_a.out_valid && bus_a.out_ready;
      if (acc) idx++;
      occ = occ + int'(acc) - int'(emit);
    end
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      check($sformatf("bp item%0d imm", i), 64'(got_q[i].imm), 64'(vecs[i+1].imm));
      check($sformatf("bp item%0d tgt", i), 64'(got_q[i].tgt), 64'(vecs[i+1].tgt));
    end

    // Reset with two entries in flight.
    @(posedge clk); #1;
    bus_a.out_ready = 1'b0; drive_a(vecs[7]); bus_a.in_valid = 1'b1;
    @(posedge clk); #1;
    drive_a(vecs[0]);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    check("pre-reset out_valid", 64'(bus_a.out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", 64'(bus_a.out_valid), 64'd0);
    check("midrst err_cnt",   64'(bus_a.err_cnt), 64'd0);
    check("midrst out_imm",   64'(bus_a.out_imm), 64'd0);
    check("midrst out_err",   64'(bus_a.out_err), 64'd0);
    @(negedge clk); rst_n = 1'b1; bus_a.out_ready = 1'b1;
    @(posedge clk); #1;
    drive_a(vecs[4]); bus_a.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
    check("postrst one edge valid", 64'(bus_a.out_valid), 64'd0);
    @(posedge clk); #1;
    check("postrst two edge valid", 64'(bus_a.out_valid), 64'd1);
    check("postrst imm", 64'(bus_a.out_imm), 64'h1234_5000);

    // XLEN=64 extension and 2-bit counter saturation on dut_b.
    run_b("b U64", 32'h800000B7, 3'b100, 64'h0000_0001_0000_0000,
          64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, 1'b0);
    run_b("b I64", 32'hFFF00093, 3'b000, 64'h10,
          64'hFFFF_FFFF_FFFF_FFFF, 64'hF, 1'b0);
    run_b("b ill1", 32'hFFF00093, 3'b110, 64'h20, 64'd0, 64'h20, 1'b1);
    run_b("b ill2", 32'hFFF00093, 3'b110, 64'h24, 64'd0, 64'h24, 1'b1);
    @(posedge clk); #1;
    check("b err_cnt two", 64'(bus_b.err_cnt), 64'd2);
    run_b("b ill3", 32'hFFF00093, 3'b111, 64'h28, 64'd0, 64'h28, 1'b1);
    run_b("b ill4", 32'hFFF00093, 3'b110, 64'h2C, 64'd0, 64'h2C, 1'b1);
    run_b("b ill5", 32'hFFF00093, 3'b110, 64'h30, 64'd0, 64'h30, 1'b1);
    @(posedge clk); #1;
    check("b err_cnt saturated", 64'(bus_b.err_cnt), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
